// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared peripheral bus.
// The winning command is latched at grant; every output is registered.
module io_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_value,
  input  logic [2:0]  m0_data_size,
  output logic        m0_ack,
  output logic [31:0] m0_read_value,
  output logic        m0_error,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_value,
  input  logic [2:0]  m1_data_size,
  output logic        m1_ack,
  output logic [31:0] m1_read_value,
  output logic        m1_error,
  output logic        p_valid,
  output logic        p_write,
  output logic [31:0] p_address,
  output logic [31:0] p_write_value,
  output logic [2:0]  p_data_size,
  input  logic        p_ready,
  input  logic [31:0] p_read_value
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_valid_q, p_valid_d;
  logic          p_write_q, p_write_d;
  logic [31:0]   p_addr_q, p_addr_d;
  logic [31:0]   p_wdata_q, p_wdata_d;
  logic [2:0]    p_size_q, p_size_d;
  logic          m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [31:0]   m0_rd_q, m0_rd_d, m1_rd_q, m1_rd_d;
  logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;

  logic          grant;
  logic          finish;
  logic [31:0]   cap_val;
  logic          cap_err;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    p_valid_d = p_valid_q;
    p_write_d = p_write_q;
    p_addr_d  = p_addr_q;
    p_wdata_d = p_wdata_q;
    p_size_d  = p_size_q;
    m0_ack_d  = 1'b0;
    m1_ack_d  = 1'b0;
    m0_rd_d   = m0_rd_q;
    m1_rd_d   = m1_rd_q;
    m0_err_d  = m0_err_q;
    m1_err_d  = m1_err_q;
    grant     = 1'b0;
    finish    = 1'b0;
    cap_val   = '0;
    cap_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester that did not win last time goes next.
          grant     = (m0_req && m1_req) ? ~last_q : m1_req;
          owner_d   = grant;
          last_d    = grant;
          cnt_d     = '0;
          p_valid_d = 1'b1;
          p_write_d = grant ? m1_write       : m0_write;
          p_addr_d  = grant ? m1_address     : m0_address;
          p_wdata_d = grant ? m1_write_value : m0_write_value;
          p_size_d  = grant ? m1_data_size   : m0_data_size;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (p_ready) begin
          finish  = 1'b1;
          cap_val = p_write_q ? '0 : p_read_value;
        end else if (cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          cap_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (finish) begin
          p_valid_d = 1'b0;
          state_d   = RESP;
          if (owner_q) begin
            m1_ack_d = 1'b1;
            m1_rd_d  = cap_val;
            m1_err_d = cap_err;
          end else begin
            m0_ack_d = 1'b1;
            m0_rd_d  = cap_val;
            m0_err_d = cap_err;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      p_valid_q <= 1'b0;
      p_write_q <= 1'b0;
      p_addr_q  <= '0;
      p_wdata_q <= '0;
      p_size_q  <= '0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_rd_q   <= '0;
      m1_rd_q   <= '0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      p_valid_q <= p_valid_d;
      p_write_q <= p_write_d;
      p_addr_q  <= p_addr_d;
      p_wdata_q <= p_wdata_d;
      p_size_q  <= p_size_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
      m0_rd_q   <= m0_rd_d;
      m1_rd_q   <= m1_rd_d;
      m0_err_q  <= m0_err_d;
      m1_err_q  <= m1_err_d;
    end
  end

  assign m0_ack        = m0_ack_q;
  assign m0_read_value = m0_rd_q;
  assign m0_error      = m0_err_q;
  assign m1_ack        = m1_ack_q;
  assign m1_read_value = m1_rd_q;
  assign m1_error      = m1_err_q;
  assign p_valid       = p_valid_q;
  assign p_write       = p_write_q;
  assign p_address     = p_addr_q;
  assign p_write_value = p_wdata_q;
  assign p_data_size   = p_size_q;

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Arbitrates one shared peripheral bus between two requesters: the CPU datapath's IO port (requester 0) and a debug/host loader (requester 1). Each owner sees a level req/ack handshake. The arbiter latches the winning command, drives a valid/ready peripheral bus, and returns read data or a timeout error. It sits between the datapath IO interface (io_address, io_write_value, io_read_value, io_read_en/io_write_en, io_data_size) and the peripheral decode logic. The CPU stall logic uses m0_req & ~m0_ack.

## Interface
- TIMEOUT, 16, number of ACCESS cycles without p_ready before the transaction is aborted with an error; legal range 2..256.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 transaction request; held high until m0_ack.
- m0_write  in  1  1 = write, 0 = read.
- m0_address  in  32  byte address.
- m0_write_value  in  32  write data.
- m0_data_size  in  3  access size code, passed through unchanged.
- m0_ack  out  1  one-cycle completion pulse.
- m0_read_value  out  32  read data; valid while m0_ack=1, held until this requester's next ack.
- m0_error  out  1  timeout flag, qualified by m0_ack.
- m1_req, m1_write, m1_address, m1_write_value, m1_data_size, m1_ack, m1_read_value, m1_error: identical to the m0_ ports, for requester 1.
- p_valid  out  1  peripheral command valid.
- p_write  out  1  latched write flag.
- p_address  out  32  latched address.
- p_write_value  out  32  latched write data.
- p_data_size  out  3  latched size code.
- p_ready  in  1  peripheral completes the command this cycle.
- p_read_value  in  32  peripheral read data, sampled when p_valid & p_ready.

## Operation
- **States.** The state machine has three states: IDLE, ACCESS, RESP. It also keeps a 1-bit owner register, a 1-bit last_grant register, and a timeout counter sized $clog2(TIMEOUT).
- **IDLE.**
  - If exactly one req is high, grant it.
  - If both are high, grant the requester other than last_grant (round-robin).
  - On a grant: latch that requester's write/address/write_value/data_size into the p_ command registers, set owner, set last_grant=owner, clear the counter, and go to ACCESS.
  - With no req, stay in IDLE.
- **ACCESS.**
  - p_valid=1; the p_ command outputs are stable for the whole state.
  - On p_ready=1: capture p_read_value (capture 0 if p_write=1), clear error, go to RESP.
  - Else, if counter == TIMEOUT-1: capture 0, set error, go to RESP.
  - Else: increment the counter.
  - If p_ready arrives in the same cycle the timeout would fire, p_ready wins and no error is raised.
- **RESP.**
  - Drive owner's ack=1 with its read_value and error; the other requester's ack stays 0.
  - Requests are ignored in this state. Return to IDLE.
- **Request protocol.**
  - A req still high in the cycle after ack counts as a new transaction (the CPU's next IO instruction).
  - Requests that drop before their grant are legal and simply not served.
  - The arbiter never reads requester inputs after the IDLE grant edge.
- **Port isolation.** The non-owner's ack, read_value and error are unaffected by the other requester's transactions.
- **Reset.** Synchronous reset at any edge sets:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), counter=0;
  - every output to 0: p_valid, p_write, p_address, p_write_value, p_data_size, both acks, both read_values, both errors.
  - Reset during ACCESS or RESP abandons the transaction: no ack is issued and p_valid is 0 in the first cycle after the reset edge.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- **Minimum latency.** Request sampled in IDLE at cycle 0 → p_valid high in cycle 1 → if p_ready=1 in cycle 1, ack in cycle 2. That is three cycles from req to ack inclusive.
- **Peripheral wait states.** Each cycle of p_ready=0 in ACCESS adds one cycle of latency.
- **Timeout.** p_valid is high for exactly TIMEOUT cycles, and ack follows in the next cycle: TIMEOUT+2 cycles from the grant edge.
- **Throughput.** Back-to-back transactions take at least 3 cycles each, since an IDLE cycle always separates RESP from the next ACCESS.
- **Fairness.** Under continuous contention, grants strictly alternate 0,1,0,1…

## Test plan
- **Single CPU read.** m0_req=1, m0_write=0, m0_address=0x0000_1000, p_ready=1 in the first ACCESS cycle, p_read_value=0xCAFE_0001 → p_valid high for 1 cycle with p_address=0x1000; m0_ack in cycle 2 with m0_read_value=0xCAFE_0001, m0_error=0; m1_ack stays 0.
- **Write with wait states.** m1_req write, address 0x2004, data 0x55AA_55AA, size 3'b010, p_ready delayed 3 cycles → p_valid high for 4 cycles with p_write_value=0x55AA_55AA and p_data_size=010; m1_ack follows with m1_read_value=0.
- **Contention.** Both reqs held high across four transactions, p_ready always 1 → grant order 0,1,0,1; each transaction takes 3 cycles; no double ack.
- **Timeout.** TIMEOUT=16, read, p_ready held 0 → p_valid high exactly 16 cycles, then m0_ack=1, m0_error=1, m0_read_value=0. Repeat with p_ready=1 on the 16th ACCESS cycle → m0_error=0 and data captured.
- **Reset mid-transaction.** Assert reset on the 2nd ACCESS cycle → next cycle p_valid=0, both acks 0, state IDLE; a subsequent simultaneous request grants requester 0.
- **Command stability.** m0 inputs change while in ACCESS → p_address/p_write_value keep the values latched at the grant.
